spi_slave_rx_fifo: RTL and testbench
====================================

# spi_slave_rx_fifo

Clock-domain receive buffer placed directly downstream of the SPI slave shifter. It watches the raw `ss`/`sck` bus lines, counts bits in the system clock domain, and captures the slave's parallel `rx` word once a full word has been shifted in. Completed words are queued in a first-word-fall-through FIFO and handed to system logic over a valid/ready port, with sticky overflow and frame-error status.

## Interface
- `SIZE`, 8: word width; must match the slave shifter's width.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `clk`  in  1  system clock; must be at least 8× the `sck` frequency.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ss`  in  1  raw slave-select from the bus, active-low, asynchronous to `clk`.
- `sck`  in  1  raw SPI clock from the bus, asynchronous to `clk`.
- `rx`  in  SIZE  parallel word from the slave shifter; changes only on `sck` rising edges.
- `rd_data`  out  SIZE  head-of-FIFO word; reads 0 whenever `rd_valid`=0.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a completed word was dropped.
- `ovf_clr`  in  1  single-cycle clear of `overflow`.
- `frame_err`  out  1  sticky partial-word flag; present only with `SPI_RX_FRAME_ERR_EN`.

## Operation
- Synchronisers: `ss` and `sck` each pass through 2 flops (`ss_s`, `sck_s`). A third flop `sck_d` holds the previous `sck_s`. The edge strobe is `sck_rise = sck_s & ~sck_d`.
- Bit counter `bit_cnt` (0..SIZE-1):
  - While `ss_s`=1, `bit_cnt` is held at 0.
  - While `ss_s`=0, `bit_cnt` increments on each `sck_rise`.
  - On a `sck_rise` with `bit_cnt`=SIZE-1, `bit_cnt` wraps to 0 and `cap_pend` is set for one cycle.
- Capture: when `cap_pend`=1, the block registers `rx` into `cap_word` and asserts `push` on the next cycle. `rx` has been stable for at least 3 `clk` by then.
- FIFO: `DEPTH` entries with wrapping read and write pointers of $clog2(DEPTH) bits, plus `level`.
  - A pop occurs on `rd_valid & rd_ready`.
  - A push is accepted if `level` < DEPTH, or if a pop occurs in the same cycle.
  - A push with `level`=DEPTH and no pop discards the word and sets `overflow`. FIFO contents are unchanged.
  - Push and pop in the same cycle with `level`=0: the pop is ignored (`rd_valid` is 0); the word is written and `rd_valid` rises next cycle. There is no bypass.
  - Push and pop in the same cycle otherwise: `level` is unchanged.
- `overflow`: setting takes priority over `ovf_clr` in the same cycle.
- `ss_s` rising with `bit_cnt`≠0: the partial word is discarded and nothing is pushed.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `level`=0, `overflow`=0, `frame_err`=0, `bit_cnt`=0, pointers=0, all synchroniser flops=0 except `ss` stages, which reset to 1.
- Latency: the last `sck` rising edge is first sampled at clk edge E0.
  - `sck_s`=1 after E1.
  - `sck_rise` high in the cycle after E1; `cap_pend`=1 after E2.
  - `push` after E3; the word is written at E4.
  - `rd_valid`=1 and `level` incremented after E4.
- Throughput: one word per SIZE `sck` periods, well below one push per clk. The FIFO never sees two pushes closer than 8 clk apart.
- An `ss` deassertion mid-word takes effect 2 clk after it is sampled.
- Reset mid-transfer discards the counter, pending capture and FIFO contents.

## Configuration
- `SPI_RX_FRAME_ERR_EN` defined: the `frame_err` port exists. It is set on any `ss_s` rising edge with `bit_cnt`≠0 and cleared by `ovf_clr` (set wins).
- Undefined: the port and its logic are removed. Partial words are still silently discarded.

## Test plan
- Reset, then one 8-bit frame carrying 0xA5 (fclk=16×fsck) -> `rd_valid` rises 4 clk after the last `sck` edge is sampled; `rd_data`=0xA5, `level`=1; a pop returns `level` to 0 and `rd_data` to 0.
- Three back-to-back words 0x01, 0x02, 0x03 within one `ss` low, with `rd_ready`=0 -> `level`=3; they are popped in order 0x01, 0x02, 0x03.
- Fill with DEPTH=16 words, then send 0xFF with no pop -> `overflow`=1, `level`=16, head word unchanged; `ovf_clr` pulse -> `overflow`=0.
- FIFO full and `rd_ready`=1 in the same cycle the 17th word pushes -> no overflow, `level` stays 16, the new word is last out.
- `ss` raised after 5 bits, then a full 0x3C frame -> only 0x3C is queued; `frame_err`=1 with the macro defined, port absent without it.
- `rst_n` asserted mid-frame with `level`=4 -> all outputs return to their reset values immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/spi_slave_rx_fifo_if.sv
// Bus-side and consumer-side signals of the SPI receive FIFO.
// frame_err is present only when SPI_RX_FRAME_ERR_EN is defined.
interface spi_slave_rx_fifo_if #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16
);
  logic                     ss;
  logic                     sck;
  logic [SIZE-1:0]          rx;
  logic [SIZE-1:0]          rd_data;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic                     ovf_clr;
`ifdef SPI_RX_FRAME_ERR_EN
  logic                     frame_err;
`endif

  modport slave (
    input  ss, sck, rx, rd_ready, ovf_clr,
`ifdef SPI_RX_FRAME_ERR_EN
    output frame_err,
`endif
    output rd_data, rd_valid, level, overflow
  );

  modport master (
    output ss, sck, rx, rd_ready, ovf_clr,
`ifdef SPI_RX_FRAME_ERR_EN
    input  frame_err,
`endif
    input  rd_data, rd_valid, level, overflow
  );
endinterface

// File: rtl/spi_slave_rx_fifo.sv
// SPI slave receive buffer: synchronises ss/sck, counts bits, captures rx into a FWFT FIFO.
// Optional sticky partial-word flag under SPI_RX_FRAME_ERR_EN.
module spi_slave_rx_fifo #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_slave_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic ss_m, ss_s, sck_m, sck_s, sck_d;
  logic sck_rise;

  // ss stages reset high so an idle bus looks deselected out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_m  <= 1'b1;
      ss_s  <= 1'b1;
      sck_m <= 1'b0;
      sck_s <= 1'b0;
      sck_d <= 1'b0;
    end else begin
      ss_m  <= bus.ss;
      ss_s  <= ss_m;
      sck_m <= bus.sck;
      sck_s <= sck_m;
      sck_d <= sck_s;
    end
  end

  assign sck_rise = sck_s & ~sck_d;

  logic [CW-1:0]   bit_cnt;
  logic            cap_pend;
  logic            push;
  logic [SIZE-1:0] cap_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      cap_pend <= 1'b0;
      push     <= 1'b0;
      cap_word <= '0;
    end else begin
      cap_pend <= 1'b0;
      push     <= cap_pend;
      if (cap_pend) cap_word <= bus.rx;
      if (ss_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        if (bit_cnt == CW'(SIZE-1)) begin
          bit_cnt  <= '0;
          cap_pend <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            full, pop, wr_en;

  assign full  = (level == LW'(DEPTH));
  assign pop   = bus.rd_valid & bus.rd_ready;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= cap_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign bus.rd_valid = (level != '0);
  assign bus.rd_data  = bus.rd_valid ? mem[rd_ptr] : '0;
  assign bus.level    = level;

  logic overflow;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   overflow <= 1'b0;
    else if (push & full & ~pop)  overflow <= 1'b1;
    else if (bus.ovf_clr)         overflow <= 1'b0;
  end
  assign bus.overflow = overflow;

`ifdef SPI_RX_FRAME_ERR_EN
  logic ss_d, frame_err;
  // bit_cnt still holds the partial count in the first cycle ss_s is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_d      <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      ss_d <= ss_s;
      if (ss_s & ~ss_d & (bit_cnt != '0)) frame_err <= 1'b1;
      else if (bus.ovf_clr)               frame_err <= 1'b0;
    end
  end
  assign bus.frame_err = frame_err;
`endif
endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// Directed bench for spi_slave_rx_fifo: latency, ordering, overflow, full+pop, partial frames, reset.
// Exercises frame_err when SPI_RX_FRAME_ERR_EN is defined.
module tb_spi_slave_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spi_slave_rx_fifo_if #(.SIZE(8), .DEPTH(16)) bus ();

  spi_slave_rx_fifo #(.SIZE(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // sck period 160 ns = 16 clk
  task automatic sck_bit(input logic b);
    bus.sck = 1'b1;
    bus.rx  = {bus.rx[6:0], b};
    #80;
    bus.sck = 1'b0;
    #80;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) sck_bit(w[7-i]);
  endtask

  task automatic frame_head(input logic [7:0] w);
    @(negedge clk);
    bus.ss = 1'b0;
    #80;
    send_bits(w, 7);
  endtask

  task automatic last_rise(input logic b);
    bus.sck = 1'b1;
    bus.rx  = {bus.rx[6:0], b};
  endtask

  task automatic frame_tail();
    #80;
    bus.sck = 1'b0;
    #80;
    bus.ss = 1'b1;
    #160;
  endtask

  task automatic send_word(input logic [7:0] w);
    frame_head(w);
    last_rise(w[0]);
    frame_tail();
  endtask

  task automatic fill16(input logic [7:0] base);
    @(negedge clk);
    bus.ss = 1'b0;
    #80;
    for (int i = 0; i < 16; i++) send_bits(base + 8'(i), 8);
    #80;
    bus.ss = 1'b1;
    #160;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, {31'd0, bus.rd_valid}, 32'd1);
    chk(tag, {24'd0, bus.rd_data}, {24'd0, exp});
    bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ss = 1'b1; bus.sck = 1'b0; bus.rx = 8'h00;
    bus.rd_ready = 1'b0; bus.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_data",  {24'd0, bus.rd_data}, 32'd0);
    chk("rst_level", {27'd0, bus.level}, 32'd0);
    chk("rst_ovf",   {31'd0, bus.overflow}, 32'd0);
`ifdef SPI_RX_FRAME_ERR_EN
    chk("rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single word, latency E0 -> valid after E4
    frame_head(8'hA5);
    last_rise(1'b1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("lat_e3_valid", {31'd0, bus.rd_valid}, 32'd0);
    @(posedge clk);
    #1 chk("lat_e4_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("lat_data",  {24'd0, bus.rd_data}, 32'hA5);
    chk("lat_level", {27'd0, bus.level}, 32'd1);
    frame_tail();
    pop_chk("a5_pop", 8'hA5);
    chk("a5_level0", {27'd0, bus.level}, 32'd0);
    chk("a5_data0",  {24'd0, bus.rd_data}, 32'd0);
    chk("a5_valid0", {31'd0, bus.rd_valid}, 32'd0);

    // three words within one ss low
    @(negedge clk);
    bus.ss = 1'b0;
    #80;
    send_bits(8'h01, 8);
    send_bits(8'h02, 8);
    send_bits(8'h03, 8);
    #80;
    bus.ss = 1'b1;
    #160;
    @(negedge clk);
    chk("b2b_level", {27'd0, bus.level}, 32'd3);
    pop_chk("b2b_w1", 8'h01);
    pop_chk("b2b_w2", 8'h02);
    pop_chk("b2b_w3", 8'h03);
    chk("b2b_empty", {27'd0, bus.level}, 32'd0);

    // overflow on a full FIFO
    fill16(8'h10);
    @(negedge clk);
    chk("fill_level", {27'd0, bus.level}, 32'd16);
    chk("fill_noovf", {31'd0, bus.overflow}, 32'd0);
    send_word(8'hFF);
    @(negedge clk);
    chk("ovf_set",   {31'd0, bus.overflow}, 32'd1);
    chk("ovf_level", {27'd0, bus.level}, 32'd16);
    chk("ovf_head",  {24'd0, bus.rd_data}, 32'h10);
    pulse_clr();
    chk("ovf_clr",   {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 16; i++) pop_chk("ovf_drain", 8'h10 + 8'(i));
    chk("ovf_empty", {27'd0, bus.level}, 32'd0);

    // full FIFO with a pop in the push cycle
    fill16(8'h40);
    frame_head(8'h77);
    last_rise(1'b1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 bus.rd_ready = 1'b1;
    @(posedge clk);
    #1 bus.rd_ready = 1'b0;
    chk("fp_level", {27'd0, bus.level}, 32'd16);
    chk("fp_noovf", {31'd0, bus.overflow}, 32'd0);
    frame_tail();
    chk("fp_noovf2", {31'd0, bus.overflow}, 32'd0);
    for (int i = 1; i < 16; i++) pop_chk("fp_drain", 8'h40 + 8'(i));
    pop_chk("fp_last", 8'h77);
    chk("fp_empty", {27'd0, bus.level}, 32'd0);

    // partial frame then a full one
    @(negedge clk);
    bus.ss = 1'b0;
    #80;
    send_bits(8'hB0, 5);
    #80;
    bus.ss = 1'b1;
    #160;
    @(negedge clk);
    chk("part_level", {27'd0, bus.level}, 32'd0);
    send_word(8'h3C);
    @(negedge clk);
    chk("part_level1", {27'd0, bus.level}, 32'd1);
`ifdef SPI_RX_FRAME_ERR_EN
    chk("ferr_set", {31'd0, bus.frame_err}, 32'd1);
`endif
    pop_chk("part_3c", 8'h3C);
    chk("part_empty", {27'd0, bus.level}, 32'd0);
`ifdef SPI_RX_FRAME_ERR_EN
    pulse_clr();
    chk("ferr_clr", {31'd0, bus.frame_err}, 32'd0);
`endif

    // reset mid-frame with four words queued
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    send_word(8'h44);
    @(negedge clk);
    chk("mid_level4", {27'd0, bus.level}, 32'd4);
    bus.ss = 1'b0;
    #80;
    send_bits(8'hC3, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("mid_rst_level", {27'd0, bus.level}, 32'd0);
    chk("mid_rst_data",  {24'd0, bus.rd_data}, 32'd0);
    chk("mid_rst_ovf",   {31'd0, bus.overflow}, 32'd0);
    bus.ss = 1'b1;
    bus.sck = 1'b0;
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_word(8'h5A);
    @(negedge clk);
    chk("post_level", {27'd0, bus.level}, 32'd1);
    pop_chk("post_5a", 8'h5A);
    chk("post_empty", {27'd0, bus.level}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
